// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into SEG registered
// segments, each resolving WIDTH/SEG result bits, with a valid/ready handshake.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ov,
  output logic             cf,
  output logic             zero
);

  localparam int SW = WIDTH / SEG;

  logic             stall;
  logic             out_valid_reg;
  logic [WIDTH-1:0] c_reg;
  logic             ov_reg;
  logic             cf_reg;
  logic             zero_reg;

  // Element k of each array is what segment k consumes this cycle.
  logic [WIDTH-1:0] a_pipe   [SEG];
  logic [WIDTH-1:0] bb_pipe  [SEG];
  logic [WIDTH-1:0] s_pipe   [SEG];
  logic             cin_pipe [SEG];
  logic [1:0]       op_pipe  [SEG];
  logic             v_pipe   [SEG];

  assign stall    = out_valid_reg & ~out_ready;
  assign in_ready = ~stall;

  assign a_pipe[0]   = a;
  assign bb_pipe[0]  = op[1] ? ~b : b;
  assign s_pipe[0]   = '0;
  assign cin_pipe[0] = op[1];
  assign op_pipe[0]  = op;
  assign v_pipe[0]   = in_valid;

  generate
    for (genvar gi = 0; gi < SEG; gi++) begin : g_seg
      logic [SW:0]      seg_sum;
      logic [WIDTH-1:0] sum_next;

      assign seg_sum  = {1'b0, a_pipe[gi][gi*SW +: SW]} + {1'b0, bb_pipe[gi][gi*SW +: SW]}
                      + {{SW{1'b0}}, cin_pipe[gi]};
      // Upper slices of the partial sum are still zero, so OR places this slice.
      assign sum_next = s_pipe[gi] | (WIDTH'(seg_sum[SW-1:0]) << (gi*SW));

      if (gi < SEG-1) begin : g_mid
        logic [WIDTH-1:0] a_reg;
        logic [WIDTH-1:0] bb_reg;
        logic [WIDTH-1:0] s_reg;
        logic             carry_reg;
        logic [1:0]       op_reg;
        logic             valid_reg;

        // Data only loads on valid beats so bubbles never disturb held values.
        always_ff @(posedge clk) begin
          if (rst) begin
            valid_reg <= 1'b0;
            a_reg     <= '0;
            bb_reg    <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            op_reg    <= '0;
          end else if (!stall) begin
            valid_reg <= v_pipe[gi];
            if (v_pipe[gi]) begin
              a_reg     <= a_pipe[gi];
              bb_reg    <= bb_pipe[gi];
              s_reg     <= sum_next;
              carry_reg <= seg_sum[SW];
              op_reg    <= op_pipe[gi];
            end
          end
        end

        assign a_pipe[gi+1]   = a_reg;
        assign bb_pipe[gi+1]  = bb_reg;
        assign s_pipe[gi+1]   = s_reg;
        assign cin_pipe[gi+1] = carry_reg;
        assign op_pipe[gi+1]  = op_reg;
        assign v_pipe[gi+1]   = valid_reg;
      end else begin : g_last
        logic c_out;
        logic c_msb_in;

        assign c_out    = seg_sum[SW];
        assign c_msb_in = a_pipe[gi][WIDTH-1] ^ bb_pipe[gi][WIDTH-1] ^ sum_next[WIDTH-1];

        always_ff @(posedge clk) begin
          if (rst) begin
            out_valid_reg <= 1'b0;
            c_reg         <= '0;
            ov_reg        <= 1'b0;
            cf_reg        <= 1'b0;
            zero_reg      <= 1'b0;
          end else if (!stall) begin
            out_valid_reg <= v_pipe[gi];
            if (v_pipe[gi]) begin
              c_reg    <= sum_next;
              ov_reg   <= ~op_pipe[gi][0] & (c_msb_in ^ c_out);
              cf_reg   <= op_pipe[gi][1] ? ~c_out : c_out;
              zero_reg <= ~|sum_next;
            end
          end
        end
      end
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign c         = c_reg;
  assign ov        = ov_reg;
  assign cf        = cf_reg;
  assign zero      = zero_reg;

endmodule
